// File: rtl/sobel_frame_ctrl.sv
// Sobel frame controller: raster RGB in, gradient magnitude^2 and edge flag out per interior pixel.
// Optional per-frame statistics outputs are enabled with the SOBEL_FRAME_STATS_EN macro.

module g_matrix (
    input  logic             clk,
    input  logic [2:0][23:0] plus_px,
    input  logic [2:0][23:0] minus_px,
    output logic [27:0]      g2
);
    logic signed [14:0] diff_d;
    logic signed [14:0] diff_q;
    logic [14:0]        diff_abs;
    logic [27:0]        sq_d;
    logic [27:0]        sq_q;

    // 12-bit luma; weights sum to 256 so a gray level v maps to 16*v.
    function automatic logic [11:0] luma(input logic [23:0] px);
        logic [15:0] s;
        s = 16'd77 * {8'd0, px[23:16]} + 16'd150 * {8'd0, px[15:8]} + 16'd29 * {8'd0, px[7:0]};
        return s[15:4];
    endfunction

    function automatic logic [13:0] wsum(input logic [2:0][23:0] px);
        return {2'b00, luma(px[0])} + {1'b0, luma(px[1]), 1'b0} + {2'b00, luma(px[2])};
    endfunction

    always_comb begin
        diff_d   = $signed({1'b0, wsum(plus_px)}) - $signed({1'b0, wsum(minus_px)});
        diff_abs = diff_q[14] ? $unsigned(-diff_q) : $unsigned(diff_q);
        sq_d     = 28'(diff_abs[13:0]) * 28'(diff_abs[13:0]);
    end

    always_ff @(posedge clk) begin
        diff_q <= diff_d;
        sq_q   <= sq_d;
    end

    assign g2 = sq_q;
endmodule

module sobel_frame_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_sof,
    input  logic [23:0] s_data,
    input  logic [28:0] thresh,
    output logic        m_valid,
    output logic [28:0] m_mag,
    output logic        m_edge,
    output logic        m_last,
    output logic        frame_done,
    output logic        err_sof,
    output logic        busy
`ifdef SOBEL_FRAME_STATS_EN
    ,
    output logic [31:0] stat_edges,
    output logic [15:0] stat_frames
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [2:0]      tok_q, tok_d;
    logic [2:0]      last_q, last_d;
    logic [28:0]     thresh_q, thresh_d;
    logic            s_ready_q, s_ready_d;
    logic            busy_q, busy_d;
    logic            m_valid_q, m_valid_d;
    logic [28:0]     m_mag_q, m_mag_d;
    logic            m_edge_q, m_edge_d;
    logic            m_last_q, m_last_d;
    logic            frame_done_q, frame_done_d;
    logic            err_sof_q, err_sof_d;

    logic [23:0]            lb0_q [IMG_W];
    logic [23:0]            lb1_q [IMG_W];
    logic [2:0][2:0][23:0]  win_q, win_d;
    logic [27:0]            gx2, gy2;

    logic            accept, in_frame, restart, mid_sof, take, inject, px_last;
    logic [CW-1:0]   px_col;
    logic [RW-1:0]   px_row;

    assign accept   = s_valid && s_ready_q;
    assign in_frame = (state_q == FILL) || (state_q == RUN);
    assign restart  = accept && s_sof;
    assign mid_sof  = restart && in_frame;
    assign take     = accept && (s_sof || in_frame);
    // An accepted sof always lands at (0,0), whatever the counters held.
    assign px_col   = s_sof ? '0 : col_q;
    assign px_row   = s_sof ? '0 : row_q;
    assign px_last  = (px_col == COL_LAST) && (px_row == ROW_LAST);
    assign inject   = take && (px_row >= ROW_TWO) && (px_col >= COL_TWO);

    g_matrix u_gx (
        .clk      (clk),
        .plus_px  ({win_q[2][2], win_q[1][2], win_q[0][2]}),
        .minus_px ({win_q[2][0], win_q[1][0], win_q[0][0]}),
        .g2       (gx2)
    );

    g_matrix u_gy (
        .clk      (clk),
        .plus_px  ({win_q[2][2], win_q[2][1], win_q[2][0]}),
        .minus_px ({win_q[0][2], win_q[0][1], win_q[0][0]}),
        .g2       (gy2)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        thresh_d = thresh_q;
        win_d    = win_q;
        tok_d    = {tok_q[1:0], inject};
        last_d   = {last_q[1:0], inject && px_last};
        if (mid_sof) begin
            tok_d  = '0;
            last_d = '0;
        end

        m_valid_d    = tok_q[2] && !mid_sof;
        m_last_d     = m_valid_d && last_q[2];
        m_mag_d      = m_valid_d ? ({1'b0, gx2} + {1'b0, gy2}) : '0;
        m_edge_d     = m_valid_d && (m_mag_d > thresh_q);
        err_sof_d    = mid_sof;
        frame_done_d = (state_q == DRAIN) && m_last_q;

        if (restart) thresh_d = thresh;

        if (take) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_q[px_col];
            win_d[1][2] = lb0_q[px_col];
            win_d[2][2] = s_data;
            if (px_last) begin
                col_d = '0;
                row_d = '0;
            end else if (px_col == COL_LAST) begin
                col_d = '0;
                row_d = px_row + RW'(1);
            end else begin
                col_d = px_col + CW'(1);
                row_d = px_row;
            end
        end

        case (state_q)
            IDLE:    if (restart) state_d = FILL;
            FILL: begin
                if (restart)                                       state_d = FILL;
                else if (take && px_last)                          state_d = DRAIN;
                else if (take && px_row == ROW_TWO && px_col == COL_TWO) state_d = RUN;
            end
            RUN: begin
                if (restart)              state_d = FILL;
                else if (take && px_last) state_d = DRAIN;
            end
            DRAIN:   if (m_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d != DRAIN);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            tok_q        <= '0;
            last_q       <= '0;
            thresh_q     <= '0;
            s_ready_q    <= 1'b1;
            busy_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            m_mag_q      <= '0;
            m_edge_q     <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            tok_q        <= tok_d;
            last_q       <= last_d;
            thresh_q     <= thresh_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            m_valid_q    <= m_valid_d;
            m_mag_q      <= m_mag_d;
            m_edge_q     <= m_edge_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
        end
    end

    // Pixel storage carries no reset; tokens alone qualify what reaches the output.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (take) begin
            lb0_q[px_col] <= s_data;
            lb1_q[px_col] <= lb0_q[px_col];
        end
    end

    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign m_valid    = m_valid_q;
    assign m_mag      = m_mag_q;
    assign m_edge     = m_edge_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;

`ifdef SOBEL_FRAME_STATS_EN
    logic [31:0] stat_edges_q, stat_edges_d;
    logic [15:0] stat_frames_q, stat_frames_d;

    always_comb begin
        stat_edges_d  = stat_edges_q;
        stat_frames_d = stat_frames_q;
        if (restart)                    stat_edges_d = '0;
        else if (m_valid_q && m_edge_q) stat_edges_d = stat_edges_q + 32'd1;
        if (frame_done_q)               stat_frames_d = stat_frames_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_edges_q  <= '0;
            stat_frames_q <= '0;
        end else begin
            stat_edges_q  <= stat_edges_d;
            stat_frames_q <= stat_frames_d;
        end
    end

    assign stat_edges  = stat_edges_q;
    assign stat_frames = stat_frames_q;
`endif
endmodule
